tetris_move_ctrl: RTL and testbench

Parametrised piece-movement controller for the Tetris core: turns held or pressed direction/rotate buttons into single move events with auto-repeat, and runs a request/acknowledge check against the playfield collision checker before committing any move. It owns the registered position and rotation of the falling piece, handles board-edge limits and rotation wrap, and reports commits and landings to the game FSM.

---
 rtl/tetris_pkg.sv | 30 +++
 rtl/key_repeat.sv | 63 ++++++
 rtl/tetris_move_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_tetris_move_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_pkg
//  Description : Shared constants for the Tetris piece-movement logic:
//                move-type codes, move-controller FSM state encoding and a
//                rotation-increment helper that wraps modulo the number of
//                rotation states.
//  Revision    : 1.0  initial release
// ============================================================================
package tetris_pkg;

    // Move codes; also used as the index of each direction's pending bit
    localparam logic [1:0] MV_LEFT  = 2'd0;
    localparam logic [1:0] MV_RIGHT = 2'd1;
    localparam logic [1:0] MV_DOWN  = 2'd2;
    localparam logic [1:0] MV_ROT   = 2'd3;

    // Move-controller FSM encoding
    localparam int unsigned        c_ST_W     = 1;
    localparam logic [c_ST_W-1:0]  c_ST_IDLE  = 1'b0;
    localparam logic [c_ST_W-1:0]  c_ST_CHECK = 1'b1;

    // Next rotation state, wrapping to 0 after n_states-1
    function automatic int unsigned rot_inc(input int unsigned cur,
                                            input int unsigned n_states);
        return ((cur + 1) >= n_states) ? 0 : (cur + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_repeat.sv
`default_nettype none
// ============================================================================
//  Module      : key_repeat
//  Description : Rising-edge detector with delay/period auto-repeat for one
//                level button. o_evt pulses combinationally in the cycle the
//                button rises, again REPEAT_DELAY cycles later, and every
//                REPEAT_PERIOD cycles after that while the button stays high.
//                i_block suppresses events and holds the counter at 0.
//  Ports       : clk, rst     clock / synchronous active-high reset
//                i_btn        level button, synchronous to clk
//                i_block      inhibit (used for left+right both pressed)
//                o_evt        one-cycle move event
//  Revision    : 1.0  initial release
// ============================================================================
module key_repeat #(
    parameter int unsigned REPEAT_DELAY  = 12,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    input  logic i_block,
    output logic o_evt
);

    localparam int unsigned c_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned c_CNT_W = $clog2(c_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_DELAY  = c_CNT_W'(REPEAT_DELAY);
    localparam logic [c_CNT_W-1:0] c_PERIOD = c_CNT_W'(REPEAT_PERIOD);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    logic               r_prev;
    logic               r_rep;      // first auto-repeat already issued
    logic [c_CNT_W-1:0] r_cnt;      // cycles since rise / since last repeat
    logic               w_rise;
    logic               w_rep_hit;

    assign w_rise    = i_btn & ~r_prev;
    assign w_rep_hit = i_btn & r_prev & (r_cnt == (r_rep ? c_PERIOD : c_DELAY));
    assign o_evt     = ~i_block & (w_rise | w_rep_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
            r_rep  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_prev <= i_btn;
            if (!i_btn || i_block) begin
                r_rep <= 1'b0;
                r_cnt <= '0;
            end else if (w_rep_hit) begin
                // Restart at 1 so the next hit lands REPEAT_PERIOD cycles on
                r_rep <= 1'b1;
                r_cnt <= c_ONE;
            end else begin
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tetris_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_move_ctrl
//  Description : Falling-piece movement controller. Converts buttons into
//                move events (with auto-repeat), queues them as pending bits,
//                and for each one runs a req/ack collision check before
//                committing the new position/rotation. Board edges are
//                handled locally without a check; a refused or edge-blocked
//                down move reports a landing.
//  Config      : define GRAVITY_EN to add a GRAVITY_TICKS-cycle gravity
//                timer that injects down events.
//  Ports       : clk, rst                 clock / sync active-high reset
//                spawn                    new-piece pulse (priority over all)
//                btn_left/right/down/rot  level buttons
//                chk_req/x/y/rot          collision-check request + candidate
//                chk_ack, chk_ok          checker response
//                pos_x, pos_y, rot        committed piece state
//                moved, move_code         commit pulse and its move type
//                landed                   refused-down pulse
//  Revision    : 1.0  initial release
// ============================================================================
module tetris_move_ctrl
    import tetris_pkg::*;
#(
    parameter int unsigned BOARD_W       = 10,
    parameter int unsigned BOARD_H       = 20,
    parameter int unsigned POS_W         = 5,
    parameter int unsigned ROT_STATES    = 4,
    parameter int unsigned ROT_W         = 2,
    parameter int unsigned SPAWN_X       = 4,
    parameter int unsigned REPEAT_DELAY  = 12,
    parameter int unsigned REPEAT_PERIOD = 4,
    parameter int          GRAVITY_TICKS = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spawn,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_down,
    input  logic             btn_rot,
    output logic             chk_req,
    output logic [POS_W-1:0] chk_x,
    output logic [POS_W-1:0] chk_y,
    output logic [ROT_W-1:0] chk_rot,
    input  logic             chk_ack,
    input  logic             chk_ok,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic [ROT_W-1:0] rot,
    output logic             moved,
    output logic [1:0]       move_code,
    output logic             landed
);

    localparam logic [POS_W-1:0] c_X_MAX   = POS_W'(BOARD_W - 1);
    localparam logic [POS_W-1:0] c_Y_MAX   = POS_W'(BOARD_H - 1);
    localparam logic [POS_W-1:0] c_SPAWN_X = POS_W'(SPAWN_X);
    localparam logic [POS_W-1:0] c_ONE     = POS_W'(1);

    logic [c_ST_W-1:0] r_state;
    logic [3:0]        r_pend;      // indexed by move code
    logic [1:0]        r_mv;        // move type of the check in flight
    logic              r_chk_req;
    logic [POS_W-1:0]  r_chk_x, r_chk_y, r_pos_x, r_pos_y;
    logic [ROT_W-1:0]  r_chk_rot, r_rot;
    logic              r_moved, r_landed;
    logic [1:0]        r_move_code;

    logic [3:0]        w_btn;
    logic [3:0]        w_evt;
    logic [3:0]        w_evt_all;
    logic              w_lr_both;
    logic              w_grav_evt;
    logic              w_any;
    logic [1:0]        w_sel;
    logic [3:0]        w_clr;
    logic [POS_W-1:0]  w_cx, w_cy;
    logic [ROT_W-1:0]  w_crot;
    logic [ROT_W-1:0]  w_rot_nxt;
    logic              w_in_bounds;

    // ------------------------------------------------------------------
    // Button event generation
    // ------------------------------------------------------------------
    assign w_btn     = {btn_rot, btn_down, btn_right, btn_left};
    assign w_lr_both = btn_left & btn_right;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key
            key_repeat #(
                .REPEAT_DELAY  (REPEAT_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD)
            ) u_key (
                .clk     (clk),
                .rst     (rst),
                .i_btn   (w_btn[gi]),
                .i_block ((gi < 2) ? w_lr_both : 1'b0),
                .o_evt   (w_evt[gi])
            );
        end
    endgenerate

`ifdef GRAVITY_EN
    localparam int c_GRAV_W = (GRAVITY_TICKS > 1) ? $clog2(GRAVITY_TICKS) : 1;
    localparam logic [c_GRAV_W-1:0] c_GRAV_LAST = c_GRAV_W'(GRAVITY_TICKS - 1);

    logic [c_GRAV_W-1:0] r_grav;
    logic                w_commit_down;

    assign w_commit_down = (r_state == c_ST_CHECK) & chk_ack & chk_ok & (r_mv == MV_DOWN);
    assign w_grav_evt    = (r_grav == c_GRAV_LAST);

    always_ff @(posedge clk) begin
        if (rst || spawn || w_commit_down || w_grav_evt) begin
            r_grav <= '0;
        end else begin
            r_grav <= r_grav + c_GRAV_W'(1);
        end
    end
`else
    // No gravity: never fires (GRAVITY_TICKS is positive by construction)
    assign w_grav_evt = (GRAVITY_TICKS < 0);
`endif

    assign w_evt_all = w_evt | {1'b0, w_grav_evt, 2'b00};

    // ------------------------------------------------------------------
    // Pending-bit arbitration and candidate generation
    // ------------------------------------------------------------------
    assign w_rot_nxt = ROT_W'(rot_inc(32'(r_rot), ROT_STATES));

    always_comb begin
        w_any = |r_pend;
        if (r_pend[MV_LEFT])       w_sel = MV_LEFT;
        else if (r_pend[MV_RIGHT]) w_sel = MV_RIGHT;
        else if (r_pend[MV_DOWN])  w_sel = MV_DOWN;
        else                       w_sel = MV_ROT;

        w_clr = '0;
        if ((r_state == c_ST_IDLE) && w_any) begin
            w_clr[w_sel] = 1'b1;
        end
    end

    always_comb begin
        w_cx        = r_pos_x;
        w_cy        = r_pos_y;
        w_crot      = r_rot;
        w_in_bounds = 1'b1;
        case (w_sel)
            MV_LEFT: begin
                w_in_bounds = (r_pos_x != '0);
                w_cx        = r_pos_x - c_ONE;
            end
            MV_RIGHT: begin
                w_in_bounds = (r_pos_x != c_X_MAX);
                w_cx        = r_pos_x + c_ONE;
            end
            MV_DOWN: begin
                w_in_bounds = (r_pos_y != c_Y_MAX);
                w_cy        = r_pos_y + c_ONE;
            end
            default: begin
                w_crot      = w_rot_nxt;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Move FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_pend      <= '0;
            r_mv        <= MV_LEFT;
            r_chk_req   <= 1'b0;
            r_chk_x     <= '0;
            r_chk_y     <= '0;
            r_chk_rot   <= '0;
            r_pos_x     <= c_SPAWN_X;
            r_pos_y     <= '0;
            r_rot       <= '0;
            r_moved     <= 1'b0;
            r_move_code <= MV_LEFT;
            r_landed    <= 1'b0;
        end else begin
            r_moved  <= 1'b0;
            r_landed <= 1'b0;
            if (spawn) begin
                // Aborts any check in progress without reporting it
                r_state   <= c_ST_IDLE;
                r_pend    <= '0;
                r_chk_req <= 1'b0;
                r_pos_x   <= c_SPAWN_X;
                r_pos_y   <= '0;
                r_rot     <= '0;
            end else begin
                // A new event in the same cycle its bit is taken stays pending
                r_pend <= (r_pend & ~w_clr) | w_evt_all;
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_any) begin
                            if (w_in_bounds) begin
                                r_chk_x   <= w_cx;
                                r_chk_y   <= w_cy;
                                r_chk_rot <= w_crot;
                                r_chk_req <= 1'b1;
                                r_mv      <= w_sel;
                                r_state   <= c_ST_CHECK;
                            end else if (w_sel == MV_DOWN) begin
                                r_landed  <= 1'b1;
                            end
                        end
                    end
                    c_ST_CHECK: begin
                        if (chk_ack) begin
                            r_chk_req <= 1'b0;
                            r_state   <= c_ST_IDLE;
                            if (chk_ok) begin
                                r_pos_x     <= r_chk_x;
                                r_pos_y     <= r_chk_y;
                                r_rot       <= r_chk_rot;
                                r_moved     <= 1'b1;
                                r_move_code <= r_mv;
                            end else if (r_mv == MV_DOWN) begin
                                r_landed    <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state   <= c_ST_IDLE;
                        r_chk_req <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign chk_req   = r_chk_req;
    assign chk_x     = r_chk_x;
    assign chk_y     = r_chk_y;
    assign chk_rot   = r_chk_rot;
    assign pos_x     = r_pos_x;
    assign pos_y     = r_pos_y;
    assign rot       = r_rot;
    assign moved     = r_moved;
    assign move_code = r_move_code;
    assign landed    = r_landed;

endmodule
`default_nettype wire

// File: tb/tb_tetris_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tetris_move_ctrl
//  Description : Directed self-checking bench for tetris_move_ctrl (default
//                build, GRAVITY_EN undefined). Expected moved/landed events,
//                including the edge at which they appear, are queued by the
//                stimulus; a negedge monitor pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tetris_move_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spawn = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_rot = 1'b0;
    logic       chk_ack = 1'b0, chk_ok = 1'b0;
    logic       chk_req;
    logic [4:0] chk_x, chk_y, pos_x, pos_y;
    logic [1:0] chk_rot, rot, move_code;
    logic       moved, landed;

    typedef struct {
        bit is_land;
        int code;
        int x;
        int y;
        int r;
        int t;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   n_req    = 0;
    int   ack_mode = 0;     // 0 accept, 1 refuse, 2 never acknowledge

    tetris_move_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .spawn     (spawn),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_down  (btn_down),
        .btn_rot   (btn_rot),
        .chk_req   (chk_req),
        .chk_x     (chk_x),
        .chk_y     (chk_y),
        .chk_rot   (chk_rot),
        .chk_ack   (chk_ack),
        .chk_ok    (chk_ok),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .rot       (rot),
        .moved     (moved),
        .move_code (move_code),
        .landed    (landed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input bit l, input int code, input int x, input int y,
                        input int r, input int t);
        exp_t e;
        e.is_land = l; e.code = code; e.x = x; e.y = y; e.r = r; e.t = t;
        sb.push_back(e);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       btn_left  = v;
            1:       btn_right = v;
            2:       btn_down  = v;
            default: btn_rot   = v;
        endcase
    endtask

    // One-cycle press, then enough idle cycles for the move to complete
    task automatic tap(input int b);
        set_btn(b, 1'b1);
        tick(1);
        set_btn(b, 1'b0);
        tick(4);
    endtask

    // Press expected to commit at the third edge after the press cycle
    task automatic tap_exp(input int b, input int code, input int x, input int y, input int r);
        push(1'b0, code, x, y, r, cyc + 3);
        tap(b);
    endtask

    // Collision-checker model and request counter
    initial begin
        logic req_prev;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_req && !req_prev) n_req++;
            req_prev = chk_req;
            chk_ack  = chk_req && (ack_mode != 2);
            chk_ok   = chk_req && (ack_mode == 0);
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (moved && landed) begin
                n_checks++;
                n_err++;
                $display("FAIL moved_landed_overlap: got both high, expected at most one (cyc %0d)", cyc);
            end
            if (moved || landed) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_event: got moved=%0d landed=%0d code=%0d pos=(%0d,%0d,%0d) cyc %0d, expected none",
                             moved, landed, move_code, pos_x, pos_y, rot, cyc);
                end else begin
                    exp_t e;
                    bit   ok;
                    e  = sb.pop_front();
                    ok = (landed == e.is_land) && (moved == !e.is_land) &&
                         (e.is_land || (int'(move_code) == e.code)) &&
                         (int'(pos_x) == e.x) && (int'(pos_y) == e.y) &&
                         (int'(rot) == e.r) && (cyc == e.t);
                    n_checks++;
                    if (!ok) begin
                        n_err++;
                        $display("FAIL event: got land=%0d code=%0d pos=(%0d,%0d,%0d) cyc=%0d, expected land=%0d code=%0d pos=(%0d,%0d,%0d) cyc=%0d",
                                 landed, move_code, pos_x, pos_y, rot, cyc,
                                 e.is_land, e.code, e.x, e.y, e.r, e.t);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int e;
        int r0;

        // Reset state
        rst = 1'b1;
        tick(3);
        chk("rst_pos_x", pos_x, 4);
        chk("rst_pos_y", pos_y, 0);
        chk("rst_rot", rot, 0);
        chk("rst_chk_req", chk_req, 0);
        chk("rst_chk_xyr", {chk_x, chk_y, chk_rot}, 0);
        chk("rst_moved_landed", {moved, landed}, 0);
        chk("rst_move_code", move_code, 0);
        rst = 1'b0;
        tick(2);

        // Single right press, same-cycle ack
        e = cyc;
        set_btn(1, 1'b1);
        push(1'b0, 1, 5, 0, 0, e + 3);
        tick(1);
        set_btn(1, 1'b0);
        tick(1);
        chk("right_req_at_n2", chk_req, 1);
        chk("right_chk_x", chk_x, 5);
        tick(4);
        chk("right_pos_x", pos_x, 5);

        // Walk to x=9, then hold left for 30 cycles
        for (int i = 6; i <= 9; i++) tap_exp(1, 1, i, 0, 0);
        e = cyc;
        set_btn(0, 1'b1);
        push(1'b0, 0, 8, 0, 0, e + 3);
        for (int j = 1; j <= 5; j++) push(1'b0, 0, 8 - j, 0, 0, e + 11 + 4 * j);
        tick(30);
        set_btn(0, 1'b0);
        tick(6);
        chk("hold_left_pos_x", pos_x, 3);

        // Left edge
        for (int i = 2; i >= 0; i--) tap_exp(0, 0, i, 0, 0);
        r0 = n_req;
        set_btn(0, 1'b1);
        tick(1);
        set_btn(0, 1'b0);
        tick(6);
        chk("left_edge_no_req", n_req, r0);
        chk("left_edge_pos_x", pos_x, 0);

        // Right edge
        for (int i = 1; i <= 9; i++) tap_exp(1, 1, i, 0, 0);
        r0 = n_req;
        tap(1);
        tick(2);
        chk("right_edge_no_req", n_req, r0);
        chk("right_edge_pos_x", pos_x, 9);

        // Down moves, refused down at y=5, edge landing at y=19
        for (int y = 1; y <= 5; y++) tap_exp(2, 2, 9, y, 0);
        ack_mode = 1;
        push(1'b1, 0, 9, 5, 0, cyc + 3);
        tap(2);
        ack_mode = 0;
        chk("refused_down_pos_y", pos_y, 5);
        for (int y = 6; y <= 19; y++) tap_exp(2, 2, 9, y, 0);
        r0 = n_req;
        push(1'b1, 0, 9, 19, 0, cyc + 2);
        tap(2);
        chk("floor_no_req", n_req, r0);
        chk("floor_pos_y", pos_y, 19);

        // Rotation wrap 1,2,3,0,1
        for (int i = 1; i <= 5; i++) tap_exp(3, 3, 9, 19, i % 4);
        chk("rot_after_five", rot, 1);

        // Stalled check, then spawn abort
        ack_mode = 2;
        set_btn(3, 1'b1);
        tick(1);
        set_btn(3, 1'b0);
        tick(1);
        chk("stall_req_up", chk_req, 1);
        chk("stall_chk_rot", chk_rot, 2);
        tick(10);
        chk("stall_req_held", chk_req, 1);
        chk("stall_cand_stable", {chk_x, chk_y, chk_rot}, {5'd9, 5'd19, 2'd2});
        spawn = 1'b1;
        tick(1);
        spawn = 1'b0;
        chk("spawn_req_drop", chk_req, 0);
        chk("spawn_pos", {pos_x, pos_y, rot}, {5'd4, 5'd0, 2'd0});
        ack_mode = 0;
        tick(3);

        // Left and right together: nothing happens
        r0 = n_req;
        btn_left  = 1'b1;
        btn_right = 1'b1;
        tick(20);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        tick(5);
        chk("lr_both_no_req", n_req, r0);
        chk("lr_both_pos_x", pos_x, 4);

        // No gravity in the default build
        r0 = n_req;
        tick(100);
        chk("no_gravity_req", n_req, r0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
